// File: rtl/id_ex_stage.sv
// Decode-to-execute stage: 2-entry skid buffer, load-use detect, flush.
// Optional perf counters enabled by defining ID_EX_PERF_CNT_EN.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [4:0]        rd_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [XLEN-1:0]   pc_o,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o,
`endif
  output logic              load_use_stall_o
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
  } pay_t;

  pay_t in_p;
  pay_t main_q, main_d;
  pay_t skid_q, skid_d;
  logic main_v_q, main_v_d;
  logic skid_v_q, skid_v_d;
  logic hz, acc, drain;

  assign in_p = '{ctrl: ctrl_i, pc: pc_i,
                  rs1_data: rs1_data_i,
                  rs2_data: rs2_data_i,
                  imm: imm_i, rs1: rs1_i,
                  rs2: rs2_i, rd: rd_i};

  // ctrl bit 0 is MemRead: the held instruction is a load
  assign hz = main_v_q & main_q.ctrl[0]
            & (main_q.rd != 5'd0) & in_valid
            & ((rs1_i == main_q.rd)
             | (rs2_i == main_q.rd));

  assign load_use_stall_o = hz;
  assign in_ready  = ~skid_v_q & ~hz;
  assign out_valid = main_v_q;
  assign acc   = in_valid & in_ready & ~flush_i;
  assign drain = main_v_q & out_ready;

  assign ctrl_o     = main_q.ctrl;
  assign pc_o       = main_q.pc;
  assign rs1_data_o = main_q.rs1_data;
  assign rs2_data_o = main_q.rs2_data;
  assign imm_o      = main_q.imm;
  assign rs1_o      = main_q.rs1;
  assign rs2_o      = main_q.rs2;
  assign rd_o       = main_q.rd;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (drain) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (acc) begin
        main_d = in_p;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (acc) begin
      if (!main_v_q) begin
        main_d   = in_p;
        main_v_d = 1'b1;
      end else begin
        skid_d   = in_p;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (in_valid && !in_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_i && (main_v_q || skid_v_q) && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage.
// Define ID_EX_PERF_CNT_EN to also check the perf counters.
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [21:0] ctrl_i, ctrl_o;
  logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        flush_i, out_valid, out_ready;
  logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        load_use_stall_o;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_chk = 0;
  int n_fail = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_i(ctrl_i), .pc_i(pc_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_o(ctrl_o), .pc_o(pc_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o),
`ifdef ID_EX_PERF_CNT_EN
    .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o),
`endif
    .load_use_stall_o(load_use_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] IMM_X = 32'hA5A5_0000;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [21:0] ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic        ordy;
    logic        ov, ir, hz;
    logic [31:0] opc;
    logic [21:0] octrl;
  } vec_t;

  vec_t tv [23];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv,
                       input logic [31:0] pc,
                       input logic [21:0] ctrl,
                       input logic [4:0] rs1,
                       input logic [4:0] rs2,
                       input logic [4:0] rd,
                       input logic ordy,
                       input logic fl);
    in_valid   = iv;
    pc_i       = pc;
    ctrl_i     = ctrl;
    rs1_i      = rs1;
    rs2_i      = rs2;
    rd_i       = rd;
    rs1_data_i = pc + 32'd1;
    rs2_data_i = pc + 32'd2;
    imm_i      = pc ^ IMM_X;
    out_ready  = ordy;
    flush_i    = fl;
  endtask

  initial begin
    tv[0]  = '{1, 32'h100, 22'h11, 0, 0, 7, 1, 0, 1, 0, 32'h0,   22'h0};
    tv[1]  = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 1, 0, 32'h100, 22'h11};
    tv[2]  = '{1, 32'h0,   22'h0,  0, 0, 1, 0, 0, 1, 0, 32'h0,   22'h0};
    tv[3]  = '{1, 32'h4,   22'h0,  0, 0, 1, 0, 1, 1, 0, 32'h0,   22'h0};
    tv[4]  = '{1, 32'h8,   22'h0,  0, 0, 1, 0, 1, 0, 0, 32'h0,   22'h0};
    tv[5]  = '{1, 32'h8,   22'h0,  0, 0, 1, 1, 1, 0, 0, 32'h0,   22'h0};
    tv[6]  = '{1, 32'h8,   22'h0,  0, 0, 1, 0, 1, 1, 0, 32'h4,   22'h0};
    tv[7]  = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 0, 0, 32'h4,   22'h0};
    tv[8]  = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 1, 0, 32'h8,   22'h0};
    tv[9]  = '{1, 32'h20,  22'h11, 0, 0, 5, 0, 0, 1, 0, 32'h0,   22'h0};
    tv[10] = '{1, 32'h24,  22'h0,  5, 0, 1, 0, 1, 0, 1, 32'h20,  22'h11};
    tv[11] = '{1, 32'h24,  22'h0,  5, 0, 1, 1, 1, 0, 1, 32'h20,  22'h11};
    tv[12] = '{1, 32'h24,  22'h0,  5, 0, 1, 0, 0, 1, 0, 32'h0,   22'h0};
    tv[13] = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 1, 0, 32'h24,  22'h0};
    tv[14] = '{1, 32'h30,  22'h11, 0, 0, 0, 0, 0, 1, 0, 32'h0,   22'h0};
    tv[15] = '{1, 32'h34,  22'h0,  0, 0, 2, 1, 1, 1, 0, 32'h30,  22'h11};
    tv[16] = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 1, 0, 32'h34,  22'h0};
    tv[17] = '{1, 32'h40,  22'h11, 0, 0, 9, 0, 0, 1, 0, 32'h0,   22'h0};
    tv[18] = '{1, 32'h44,  22'h0,  1, 9, 3, 0, 1, 0, 1, 32'h40,  22'h11};
    tv[19] = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 1, 0, 32'h40,  22'h11};
    tv[20] = '{1, 32'h50,  22'h10, 0, 0, 9, 0, 0, 1, 0, 32'h0,   22'h0};
    tv[21] = '{1, 32'h54,  22'h0,  9, 0, 3, 1, 1, 1, 0, 32'h50,  22'h10};
    tv[22] = '{0, 32'h0,   22'h0,  0, 0, 0, 1, 1, 1, 0, 32'h54,  22'h0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pc_o", 64'(pc_o), 64'd0);
    chk("rst_ctrl_o", 64'(ctrl_o), 64'd0);
    chk("rst_hz", 64'(load_use_stall_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tv[i].iv, tv[i].pc, tv[i].ctrl, tv[i].rs1,
            tv[i].rs2, tv[i].rd, tv[i].ordy, 1'b0);
      #1;
      chk($sformatf("v%0d_out_valid", i),
          64'(out_valid), 64'(tv[i].ov));
      chk($sformatf("v%0d_in_ready", i),
          64'(in_ready), 64'(tv[i].ir));
      chk($sformatf("v%0d_hz", i),
          64'(load_use_stall_o), 64'(tv[i].hz));
      if (tv[i].ov) begin
        chk($sformatf("v%0d_pc_o", i),
            64'(pc_o), 64'(tv[i].opc));
        chk($sformatf("v%0d_ctrl_o", i),
            64'(ctrl_o), 64'(tv[i].octrl));
        chk($sformatf("v%0d_imm_o", i),
            64'(imm_o), 64'(tv[i].opc ^ IMM_X));
        chk($sformatf("v%0d_rs2_data_o", i),
            64'(rs2_data_o), 64'(tv[i].opc + 32'd2));
      end
    end

    // flush with both entries full and a new instruction offered
    @(negedge clk); drive(1, 32'h60, 0, 0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 32'h64, 0, 0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 32'h68, 0, 0, 0, 1, 0, 1);
    #1;
    chk("fl_full_in_ready", 64'(in_ready), 64'd0);
    chk("fl_full_pc_o", 64'(pc_o), 64'h60);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("fl_after%0d_out_valid", k),
          64'(out_valid), 64'd0);
      chk($sformatf("fl_after%0d_in_ready", k),
          64'(in_ready), 64'd1);
    end

    // async reset between edges while backpressured
    @(negedge clk); drive(1, 32'h70, 0, 0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 32'h74, 0, 0, 0, 1, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("ar_pre_out_valid", 64'(out_valid), 64'd1);
    chk("ar_pre_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_pc_o", 64'(pc_o), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h78, 22'h11, 0, 0, 4, 1, 0);
    #1;
    chk("ar_new_out_valid0", 64'(out_valid), 64'd0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("ar_new_out_valid1", 64'(out_valid), 64'd1);
    chk("ar_new_pc_o", 64'(pc_o), 64'h78);
    chk("ar_new_rd_o", 64'(rd_o), 64'd4);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("ar_drained", 64'(out_valid), 64'd0);

`ifdef ID_EX_PERF_CNT_EN
    chk("pc_stall_init", 64'(stall_cnt_o), 64'd0);
    chk("pc_flush_init", 64'(flush_cnt_o), 64'd0);
    @(negedge clk); drive(1, 32'h80, 0, 0, 0, 1, 0, 0);
    @(negedge clk); drive(1, 32'h84, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1, 32'h88, 0, 0, 0, 1, 0, 0);
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pc_stall_cnt", 64'(stall_cnt_o), 64'd4);
    chk("pc_flush_cnt", 64'(flush_cnt_o), 64'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
